vga_scan_gen: RTL
=================

// Module: vga_scan_gen
// PURPOSE
//  Raster scan generator: the counterpart of the sprite/ROM renderers.
//  - Drives pixel_x/pixel_y to every renderer and takes back their 24-bit color.
//  - Produces hsync/vsync/blank_n and a registered rgb_out for the display DAC/encoder.
//  - Delays sync and blank to match the renderer ROM read latency, so color and timing leave aligned.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  PIPE_LAT  1    en-cycles from pixel_x/pixel_y change to valid color_in (1..4)
//  SYNC_POL  0    sync active level (0 = active-low)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset: asynchronous, active-high
//  en           in   1   pixel-clock enable; all state advances only when en=1
//  pixel_x      out  16  current horizontal count h_cnt, zero-extended
//  pixel_y      out  16  current vertical count v_cnt, zero-extended
//  color_in     in   24  renderer color for the coordinate issued PIPE_LAT en-cycles earlier
//  rgb_out      out  24  pixel to display; 0 outside active area
//  hsync        out  1   horizontal sync, aligned with rgb_out
//  vsync        out  1   vertical sync, aligned with rgb_out
//  blank_n      out  1   1 = rgb_out is a visible pixel
//  frame_start  out  1   one-cycle pulse, coincident with the first issue of (0,0)
// BEHAVIOUR
//  - Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT likewise (525).
//  - Counters, both 16-bit registers, advance on each clk edge with en=1:
//    - h_cnt: 0..H_TOT-1, wraps to 0.
//    - v_cnt: increments only when h_cnt wraps; wraps to 0 after V_TOT-1.
//    - With en=0, counters, delay line and all outputs hold.
//  - pixel_x = h_cnt and pixel_y = v_cnt, driven straight from the registers with no
//    extra delay. They are valid in blanking too. pixel_y changes exactly once per line,
//    in the same cycle pixel_x returns to 0; renderers detect line changes from this.
//  - Raw timing per counter state:
//    - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
//    - hs  = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
//    - vs  = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (whole lines)
//  - Delay line: {act,hs,vs} pass through a PIPE_LAT-deep shift register, advanced on en.
//    The tap act_d is therefore aligned with color_in.
//  - Output register (on en): rgb_out <= act_d ? color_in : 0; blank_n <= act_d;
//    hsync <= hs_d ^ ~SYNC_POL; vsync <= vs_d ^ ~SYNC_POL.
//  - Total latency coordinate -> rgb_out/hsync/vsync/blank_n = PIPE_LAT+1 en-cycles.
//  - frame_start is registered: it is 1 for exactly the clk cycle in which h_cnt=0, v_cnt=0
//    is first presented after wrap. It is not re-asserted while en=0 stalls at (0,0).
//  - Reset, asynchronous, at any point including mid-line:
//    - h_cnt=0, v_cnt=0, delay line cleared to inactive.
//    - rgb_out=0, blank_n=0, hsync=vsync=inactive level (~SYNC_POL), frame_start=0.
//    - After release, the first en-cycle starts a fresh frame at (0,0); no partial line is
//      completed and frame_start is not pulsed for this first frame.
//  - Simultaneous h wrap and v wrap: both counters go to 0 in the same edge; frame_start pulses.
// TESTING
//  1) Assert rst mid-line at h=300,v=100 -> all outputs at reset values immediately;
//     after release, pixel_x=0, pixel_y=0.
//  2) Defaults, en=1 -> hsync low for 96 clks. Its first low cycle is 2 clks after
//     pixel_x=656. Line period is 800 clks.
//  3) Run to h=799,v=524, one edge -> pixel_x=0, pixel_y=0, frame_start=1 for one cycle.
//     vsync is low for exactly 1600 clks per frame.
//  4) Bench renderer returns color_in = {8'h0, pixel_x} delayed PIPE_LAT -> rgb_out equals
//     x for each visible pixel. Check PIPE_LAT=1 and 3: pixel 639 is output, 640 gives 0
//     with blank_n=0.
//  5) Toggle en 1/0 randomly -> counters and outputs advance only on en=1; the
//     timing/colour sequence is identical to the en=1 run when compared in en-cycles.
//  6) SYNC_POL=1 -> hsync/vsync are high only during the sync windows; reset level is 0.

Source files
------------

// File: rtl/vga_scan_gen.sv
// Raster scan generator: counters, renderer-latency-matched timing delay
// line and registered pixel/sync outputs for the display encoder.
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_LAT = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    input  logic [23:0] color_in,
    output logic [23:0] rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        frame_start
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOT - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOT - 1);
    localparam logic [15:0] H_VIS  = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_OFF = ~SYNC_POL;

    generate
        if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
            $error("vga_scan_gen: PIPE_LAT must be 1..4");
        end
    endgenerate

    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic        h_wrap;
    logic        v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 16'd1;
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign pixel_x = h_q;
    assign pixel_y = v_q;

    // Raw timing for the coordinate currently issued: {act, hs, vs}
    logic       raw_act;
    logic       raw_hs;
    logic       raw_vs;
    logic [2:0] raw;

    assign raw_act = (h_q < H_VIS) && (v_q < V_VIS);
    assign raw_hs  = (h_q >= HS_BEG) && (h_q <= HS_END);
    assign raw_vs  = (v_q >= VS_BEG) && (v_q <= VS_END);
    assign raw     = {raw_act, raw_hs, raw_vs};

    // Delay line; its last tap lines up with color_in from the renderers
    logic [PIPE_LAT-1:0][2:0] dl_q, dl_d;

    always_comb begin
        dl_d = dl_q;
        if (en) begin
            dl_d[0] = raw;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                dl_d[i] = dl_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q <= '0;
        end else begin
            dl_q <= dl_d;
        end
    end

    logic act_d;
    logic hs_d;
    logic vs_d;

    assign act_d = dl_q[PIPE_LAT-1][2];
    assign hs_d  = dl_q[PIPE_LAT-1][1];
    assign vs_d  = dl_q[PIPE_LAT-1][0];

    logic [23:0] rgb_q;
    logic        blank_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        fs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q   <= '0;
            blank_q <= 1'b0;
            hsync_q <= SYNC_OFF;
            vsync_q <= SYNC_OFF;
        end else if (en) begin
            rgb_q   <= act_d ? color_in : 24'd0;
            blank_q <= act_d;
            hsync_q <= hs_d ^ SYNC_OFF;
            vsync_q <= vs_d ^ SYNC_OFF;
        end
    end

    // Updated every clk so a stall at (0,0) drops the pulse after one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= en && h_wrap && v_wrap;
        end
    end

    assign rgb_out     = rgb_q;
    assign blank_n     = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule
